// File: rtl/event_irq_ctrl.sv
// Event-to-interrupt controller: latches single-cycle event pulses into pending flags,
// records lost events as overflow, counts events and raises a level interrupt.
module event_irq_ctrl #(
    parameter int NUM_SRC = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_SRC-1:0] event_in,
    input  logic [1:0]         addr,
    input  logic [7:0]         wrdata,
    input  logic               wr,
    output logic [7:0]         rddata,
    output logic               irq
);

    localparam logic [1:0] ADDR_PENDING  = 2'd0;
    localparam logic [1:0] ADDR_ENABLE   = 2'd1;
    localparam logic [1:0] ADDR_OVERFLOW = 2'd2;
    localparam logic [1:0] ADDR_COUNT    = 2'd3;

    logic [NUM_SRC-1:0] r_pending;
    logic [NUM_SRC-1:0] r_enable;
    logic [NUM_SRC-1:0] r_overflow;
    logic [7:0]         r_count;
    logic [7:0]         r_rddata;
    logic               r_irq;

    logic               w_wr_pending;
    logic               w_wr_enable;
    logic               w_wr_overflow;
    logic               w_wr_count;
    logic [NUM_SRC-1:0] w_pending_next;
    logic [NUM_SRC-1:0] w_enable_next;
    logic [NUM_SRC-1:0] w_overflow_next;
    logic [7:0]         w_count_next;
    logic [3:0]         w_event_cnt;
    logic               w_irq_next;
    logic [7:0]         w_pending_ext;
    logic [7:0]         w_enable_ext;
    logic [7:0]         w_overflow_ext;
    logic [7:0]         w_rddata_next;
    logic               w_wrdata_unused;

    assign w_wr_pending  = wr && (addr == ADDR_PENDING);
    assign w_wr_enable   = wr && (addr == ADDR_ENABLE);
    assign w_wr_overflow = wr && (addr == ADDR_OVERFLOW);
    assign w_wr_count    = wr && (addr == ADDR_COUNT);

    // Write data bits above NUM_SRC have no backing state.
    assign w_wrdata_unused = ^wrdata;

    // Per-source flags: an event always wins over a same-cycle W1C, so no event is lost.
    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
            assign w_pending_next[gi]  = event_in[gi]
                                       | (r_pending[gi] & ~(w_wr_pending & wrdata[gi]));
            assign w_overflow_next[gi] = (event_in[gi] & r_pending[gi])
                                       | (r_overflow[gi] & ~(w_wr_overflow & wrdata[gi]));
            assign w_enable_next[gi]   = w_wr_enable ? wrdata[gi] : r_enable[gi];
        end
    endgenerate

    always_comb begin
        w_event_cnt = 4'd0;
        for (int i = 0; i < NUM_SRC; i++) begin
            w_event_cnt = w_event_cnt + 4'(event_in[i]);
        end
    end

    // A COUNT write restarts from zero but still includes this cycle's events.
    assign w_count_next = w_wr_count ? {4'd0, w_event_cnt}
                                     : r_count + {4'd0, w_event_cnt};

    assign w_irq_next = |(w_pending_next & w_enable_next);

    always_comb begin
        w_pending_ext  = 8'd0;
        w_enable_ext   = 8'd0;
        w_overflow_ext = 8'd0;
        w_pending_ext[NUM_SRC-1:0]  = w_pending_next;
        w_enable_ext[NUM_SRC-1:0]   = w_enable_next;
        w_overflow_ext[NUM_SRC-1:0] = w_overflow_next;
    end

    // Read data returns post-update values so a read sees this cycle's writes and events.
    always_comb begin
        w_rddata_next = 8'd0;
        case (addr)
            ADDR_PENDING:  w_rddata_next = w_pending_ext;
            ADDR_ENABLE:   w_rddata_next = w_enable_ext;
            ADDR_OVERFLOW: w_rddata_next = w_overflow_ext;
            ADDR_COUNT:    w_rddata_next = w_count_next;
            default:       w_rddata_next = 8'd0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pending  <= '0;
            r_enable   <= '0;
            r_overflow <= '0;
            r_count    <= 8'd0;
            r_rddata   <= 8'd0;
            r_irq      <= 1'b0;
        end else begin
            r_pending  <= w_pending_next;
            r_enable   <= w_enable_next;
            r_overflow <= w_overflow_next;
            r_count    <= w_count_next;
            r_rddata   <= w_rddata_next;
            r_irq      <= w_irq_next;
        end
    end

    assign rddata = r_rddata;
    assign irq    = r_irq;

endmodule

// File: tb/tb_event_irq_ctrl.sv
// Self-checking bench for event_irq_ctrl: directed vector table, multi-cycle corner
// sequences and randomized traffic against a bit-array reference model.
module tb_event_irq_ctrl;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic [3:0] event_in = 4'd0;
    logic [1:0] addr = 2'd0;
    logic [7:0] wrdata = 8'd0;
    logic       wr = 1'b0;
    logic [7:0] rddata;
    logic       irq;

    int checks = 0;
    int failures = 0;

    event_irq_ctrl #(.NUM_SRC(4)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .event_in (event_in),
        .addr     (addr),
        .wrdata   (wrdata),
        .wr       (wr),
        .rddata   (rddata),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    // Reference model: one flag per source plus an integer event count.
    bit m_pend[4];
    bit m_en[4];
    bit m_ovf[4];
    int m_cnt;
    bit m_irq;
    int m_rd;

    typedef struct {
        logic [3:0] ev;
        logic [1:0] a;
        logic [7:0] wd;
        logic       w;
        logic [7:0] rd;
        logic       irq;
    } vec_t;

    vec_t vecs[18];

    function automatic vec_t mk(input logic [3:0] ev, input logic [1:0] a, input logic [7:0] wd,
                                input logic w, input logic [7:0] rd, input logic ir);
        vec_t v;
        v.ev = ev; v.a = a; v.wd = wd; v.w = w; v.rd = rd; v.irq = ir;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_pend[i] = 0; m_en[i] = 0; m_ovf[i] = 0;
        end
        m_cnt = 0; m_irq = 0; m_rd = 0;
    endtask

    task automatic model_step(input logic [3:0] ev, input logic [1:0] a,
                              input logic [7:0] wd, input logic w);
        bit was_pend[4];
        for (int i = 0; i < 4; i++) was_pend[i] = m_pend[i];
        if (w) begin
            for (int i = 0; i < 4; i++) begin
                if (a == 2'd0 && wd[i]) m_pend[i] = 0;
                if (a == 2'd1) m_en[i] = wd[i];
                if (a == 2'd2 && wd[i]) m_ovf[i] = 0;
            end
            if (a == 2'd3) m_cnt = 0;
        end
        // Events are applied after clears so they always survive a same-cycle W1C.
        for (int i = 0; i < 4; i++) begin
            if (ev[i]) begin
                if (was_pend[i]) m_ovf[i] = 1;
                m_pend[i] = 1;
            end
        end
        m_cnt = (m_cnt + $countones(ev)) % 256;
        m_irq = 0;
        m_rd = 0;
        for (int i = 0; i < 4; i++) begin
            if (m_pend[i] && m_en[i]) m_irq = 1;
            if (a == 2'd0 && m_pend[i]) m_rd += (1 << i);
            if (a == 2'd1 && m_en[i])   m_rd += (1 << i);
            if (a == 2'd2 && m_ovf[i])  m_rd += (1 << i);
        end
        if (a == 2'd3) m_rd = m_cnt;
    endtask

    // One bus/event cycle: drive inputs, advance the model, sample 1 time unit after the edge.
    task automatic cycle(input logic [3:0] ev, input logic [1:0] a,
                         input logic [7:0] wd, input logic w);
        event_in = ev; addr = a; wrdata = wd; wr = w;
        model_step(ev, a, wd, w);
        @(posedge clk);
        #1;
        $display("t=%0t ev=%b addr=%0d wr=%0b wd=%h -> rd=%h irq=%0b",
                 $time, ev, a, w, wd, rddata, irq);
        event_in = 4'd0;
        wr = 1'b0;
    endtask

    initial begin
        vecs[0]  = mk(4'b0010, 2'd0, 8'h00, 1'b0, 8'h02, 1'b0);
        vecs[1]  = mk(4'b0000, 2'd3, 8'h00, 1'b0, 8'h01, 1'b0);
        vecs[2]  = mk(4'b0000, 2'd1, 8'h0F, 1'b1, 8'h0F, 1'b1);
        vecs[3]  = mk(4'b0000, 2'd0, 8'h02, 1'b1, 8'h00, 1'b0);
        vecs[4]  = mk(4'b1000, 2'd0, 8'h00, 1'b0, 8'h08, 1'b1);
        vecs[5]  = mk(4'b0000, 2'd0, 8'h08, 1'b1, 8'h00, 1'b0);
        vecs[6]  = mk(4'b0001, 2'd0, 8'h00, 1'b0, 8'h01, 1'b1);
        vecs[7]  = mk(4'b0001, 2'd2, 8'h00, 1'b0, 8'h01, 1'b1);
        vecs[8]  = mk(4'b0000, 2'd2, 8'h01, 1'b1, 8'h00, 1'b1);
        vecs[9]  = mk(4'b0000, 2'd0, 8'h00, 1'b0, 8'h01, 1'b1);
        vecs[10] = mk(4'b0010, 2'd0, 8'h00, 1'b0, 8'h03, 1'b1);
        vecs[11] = mk(4'b0010, 2'd0, 8'h02, 1'b1, 8'h03, 1'b1);
        vecs[12] = mk(4'b0000, 2'd2, 8'h00, 1'b0, 8'h02, 1'b1);
        vecs[13] = mk(4'b0010, 2'd2, 8'h02, 1'b1, 8'h02, 1'b1);
        vecs[14] = mk(4'b0101, 2'd3, 8'hAA, 1'b1, 8'h02, 1'b1);
        vecs[15] = mk(4'b0000, 2'd3, 8'h00, 1'b0, 8'h02, 1'b1);
        vecs[16] = mk(4'b0000, 2'd0, 8'hFF, 1'b1, 8'h00, 1'b0);
        vecs[17] = mk(4'b0000, 2'd1, 8'hF0, 1'b1, 8'h00, 1'b0);

        // Reset with no clock edge yet
        #1 reset_n = 1'b0;
        model_reset();
        #1;
        chk("reset_irq", int'(irq), 0);
        chk("reset_rddata", int'(rddata), 0);

        // Events during reset are discarded
        event_in = 4'hF;
        @(posedge clk);
        #1 event_in = 4'h0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int a = 0; a < 4; a++) begin
            cycle(4'd0, 2'(a), 8'd0, 1'b0);
            chk($sformatf("post_reset_reg%0d", a), int'(rddata), 0);
        end

        for (int v = 0; v < 18; v++) begin
            cycle(vecs[v].ev, vecs[v].a, vecs[v].wd, vecs[v].w);
            chk($sformatf("vec%0d_rddata", v), int'(rddata), int'(vecs[v].rd));
            chk($sformatf("vec%0d_irq", v), int'(irq), int'(vecs[v].irq));
        end

        // Count wrap: 255 single events then four at once
        cycle(4'd0, 2'd3, 8'h00, 1'b1);
        chk("count_clear", int'(rddata), 0);
        for (int n = 0; n < 255; n++) cycle(4'b0001, 2'd3, 8'd0, 1'b0);
        chk("count_255", int'(rddata), 255);
        cycle(4'b1111, 2'd3, 8'd0, 1'b0);
        chk("count_wrap", int'(rddata), 3);

        // Mid-operation reset between clock edges
        cycle(4'd0, 2'd1, 8'h0F, 1'b1);
        chk("pre_reset_irq", int'(irq), 1);
        #3 reset_n = 1'b0;
        model_reset();
        #1;
        chk("midreset_irq", int'(irq), 0);
        chk("midreset_rddata", int'(rddata), 0);
        event_in = 4'hF;
        @(posedge clk);
        #1 event_in = 4'h0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int a = 0; a < 4; a++) begin
            cycle(4'd0, 2'(a), 8'd0, 1'b0);
            chk($sformatf("after_midreset_reg%0d", a), int'(rddata), 0);
            chk($sformatf("after_midreset_irq%0d", a), int'(irq), 0);
        end

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            logic [3:0] ev;
            logic [1:0] a;
            logic [7:0] wd;
            logic       w;
            ev = 4'($urandom & $urandom);
            a  = 2'($urandom_range(0, 3));
            wd = 8'($urandom);
            w  = ($urandom_range(0, 2) == 0);
            cycle(ev, a, wd, w);
            chk($sformatf("rand%0d_rddata", n), int'(rddata), m_rd);
            chk($sformatf("rand%0d_irq", n), int'(irq), int'(m_irq));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/event_irq_ctrl.md
# event_irq_ctrl

Event-to-interrupt controller that consumes single-cycle event pulses already resynchronised into the CPU clock domain by the pulse-crossing synchronisers, for example video line and vblank events. It latches each event into a per-source pending flag, flags lost events as overflow, and counts total events. It drives a registered, level-sensitive interrupt request to the CPU. Software services it through a small 4-register bus interface with write-1-to-clear semantics.

## Interface
- NUM_SRC, default 4: number of event sources; legal range 1–8.
- clk  input  1: system clock; all logic is clocked on the rising edge.
- reset_n  input  1: asynchronous, active-low reset.
- event_in  input  NUM_SRC: one-cycle event pulses, one bit per source; synchronous to clk.
- addr  input  2: register select.
- wrdata  input  8: write data.
- wr  input  1: write strobe; one write per cycle when high.
- rddata  output  8: registered read data.
- irq  output  1: interrupt request, active-high level.

## Operation
- State:
  - pending[NUM_SRC-1:0]
  - enable[NUM_SRC-1:0]
  - overflow[NUM_SRC-1:0]
  - count[7:0]
- Bits above NUM_SRC-1 read as 0 and ignore writes.
- Register map:
  - addr 0 PENDING: read pending. Writing 1 to a bit clears it; writing 0 has no effect.
  - addr 1 ENABLE: plain read/write.
  - addr 2 OVERFLOW: read overflow; W1C.
  - addr 3 COUNT: read count. Any write clears it; the written data is ignored.
- Event set: event_in[i]=1 in a cycle sets pending[i] at the next edge.
- Overflow: event_in[i]=1 while pending[i] is already 1 at that edge sets overflow[i]. This applies whether or not a W1C of pending[i] occurs in the same cycle.
- Set/clear collision: event_in[i]=1 together with a W1C of pending[i] in the same cycle leaves pending[i]=1. Set has priority and the event is never lost.
- The same priority rule applies to overflow[i]: a set and a W1C in the same cycle leave the bit at 1.
- Enable gates only irq. Disabled sources still set pending and overflow and still count.
- Count:
  - Each cycle, count_next = count + popcount(event_in), computed modulo 256 (wraps, no saturation).
  - When a COUNT write and events occur in the same cycle, count_next = popcount(event_in).
- irq: registered; irq_next = |(pending_next & enable_next).
- Read path: rddata_next = mux(addr) of the register values after this cycle's updates, i.e. the _next values. There is no read strobe and reads have no side effects.

## Timing
- Reset values while reset_n=0 (asynchronous, immediate):
  - pending=0, enable=0, overflow=0, count=0
  - rddata=0x00, irq=0
- Release of reset is synchronous: first update on the first clk edge with reset_n=1.
- Event to pending: event in cycle n, pending visible in cycle n+1.
- Event to irq: event in cycle n, irq high in cycle n+1, provided enable was already set.
- Enabling a source that is already pending raises irq one cycle after the ENABLE write.
- W1C of the last enabled pending bit in cycle n drops irq in cycle n+1, unless a same-cycle event re-sets that bit or another enabled bit.
- Read latency:
  - addr presented in cycle n returns rddata in cycle n+1.
  - That data reflects any write or event applied at the cycle-n edge.
- Reset asserted mid-operation: all state clears at once and irq drops without waiting for a clock. Event pulses during reset are discarded.
- Throughput: one write and up to NUM_SRC events per cycle; no stall conditions.

## Test plan
- Reset: drive reset_n low with no clock edge → irq=0 and rddata=0x00. Release reset, pulse event_in=4'b0010 with enable=0 → PENDING=0x02, irq remains 0, COUNT=1.
- Enable path: write ENABLE=0x0F, then pulse event_in[3] in cycle n → irq=1 in cycle n+1. W1C PENDING with 0x08 → irq=0 on the following cycle.
- Overflow: pulse event_in[0] twice with no W1C in between → PENDING=0x01, OVERFLOW=0x01. W1C OVERFLOW with 0x01 → OVERFLOW=0x00 while PENDING stays 0x01.
- Collision: with pending[1]=1, W1C PENDING=0x02 in the same cycle as event_in[1] → PENDING=0x02 and OVERFLOW=0x02.
- Count: 255 single events then event_in=4'b1111 → COUNT=0x03 (wrap). A COUNT write in the same cycle as event_in=4'b0101 → COUNT=0x02.
- Reset mid-operation: irq=1 with a nonzero COUNT, assert reset_n between clock edges → irq=0 at once. After release, every register reads 0x00.
